// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO feeding an LSB-first serialiser
// with optional parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BIT     = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BIT-1:0]           tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(STOP_CLKS + 1);
  localparam int IDX_W     = $clog2(DATA_BIT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  state_t               next_state;
  logic [DATA_BIT-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BIT-1:0]  head;
  logic [DATA_BIT-1:0]  shift_reg;
  logic                 parity_bit;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_data;
  logic                 fifo_empty;
  logic                 tx_next;
  logic                 done_next;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign tx_ready   = (fifo_count != (PTR_W + 1)'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign busy       = (state != IDLE);
  assign last_data  = (bit_idx == IDX_W'(DATA_BIT - 1));

  // The stop phase is timed as one long interval covering all stop bits.
  always_comb begin
    bit_end = 1'b0;
    case (state)
      IDLE:    bit_end = 1'b0;
      STOP:    bit_end = (clk_cnt == CNT_W'(STOP_CLKS - 1));
      default: bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!fifo_empty) next_state = START;
      START:  if (bit_end) next_state = DATA;
      DATA:   if (bit_end && last_data) next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) next_state = STOP;
      STOP:   if (bit_end) next_state = fifo_empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // tx is registered, so this block computes the level for the next bit period.
  always_comb begin
    pop       = 1'b0;
    tx_next   = tx;
    done_next = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_next = 1'b0;
        end
      end
      START: begin
        if (bit_end) tx_next = shift_reg[0];
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) tx_next = (PARITY_EN != 0) ? parity_bit : 1'b1;
          else           tx_next = shift_reg[1];
        end
      end
      PARITY: begin
        if (bit_end) tx_next = 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          done_next = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            tx_next = 1'b0;
          end else begin
            tx_next = 1'b1;
          end
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx      <= tx_next;
      tx_done <= done_next;
      if (state == IDLE || bit_end) clk_cnt <= '0;
      else                          clk_cnt <= clk_cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 1'b1;
      if (pop) begin
        shift_reg  <= head;
        parity_bit <= (^head) ^ (PARITY_ODD != 0);
      end else if (state == DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats share one clock and reset, and
// every waveform is predicted from frame arithmetic rather than the FSM.
module tb_uart_tx_fifo;

  localparam int CPB = 10;
  localparam int PE_TAB  [4] = '{0, 1, 1, 0};
  localparam int ODD_TAB [4] = '{0, 0, 1, 0};
  localparam int SB_TAB  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       valid   [4];
  logic       ready   [4];
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic [4:0] count_w [4];

  int passed = 0;
  int total  = 0;

  logic [7:0] stim_q [$];
  logic [7:0] exp_q  [$];
  logic [7:0] rx_q   [$];
  logic       mon_en = 1'b0;
  logic [7:0] mon_byte;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BIT(8), .FIFO_DEPTH(16),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[0]), .tx_ready(ready[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .fifo_count(count_w[0]));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BIT(8), .FIFO_DEPTH(16),
                 .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[1]), .tx_ready(ready[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .fifo_count(count_w[1]));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BIT(8), .FIFO_DEPTH(16),
                 .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[2]), .tx_ready(ready[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .fifo_count(count_w[2]));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BIT(8), .FIFO_DEPTH(16),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[3]), .tx_ready(ready[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]), .fifo_count(count_w[3]));

  function automatic int frame_len(input int idx);
    return (1 + 8 + PE_TAB[idx] + SB_TAB[idx]) * CPB;
  endfunction

  // Line level at cycle offset o into a frame carrying byte b.
  function automatic logic model_level(input int idx, input logic [7:0] b, input int o);
    int bn;
    bn = o / CPB;
    if (bn == 0) return 1'b0;
    if (bn <= 8) return b[bn-1];
    if (PE_TAB[idx] != 0 && bn == 9) return (^b) ^ (ODD_TAB[idx] != 0);
    return 1'b1;
  endfunction

  // Serial receiver on the 8N1 instance, sampling mid-bit from the falling start edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx_w[0] === 1'b0) begin
        repeat (14) @(negedge clk);
        mon_byte[0] = tx_w[0];
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_byte[i] = tx_w[0];
        end
        repeat (CPB) @(negedge clk);
        total++;
        if (tx_w[0] !== 1'b1) $display("[TB] FAIL monitor stop bit got %b want 1", tx_w[0]);
        else passed++;
        rx_q.push_back(mon_byte);
      end
    end
  end

  // Pushes stim_q on consecutive edges, then checks every cycle until idle again.
  task automatic run_frames(input int idx, input string name);
    int n, flen, f, o, pushes, pops;
    logic exp_tx, exp_done, exp_busy;
    logic [4:0] exp_cnt;
    n = stim_q.size();
    flen = frame_len(idx);
    for (int k = 0; k <= n * flen + 2; k++) begin
      if (k < n) begin
        tx_data = stim_q[k];
        valid[idx] = 1'b1;
      end else begin
        valid[idx] = 1'b0;
        tx_data = 8'($urandom);
      end
      @(posedge clk); #1;
      if (k >= 1 && k <= n * flen) begin
        f = (k - 1) / flen;
        o = (k - 1) % flen;
        exp_tx = model_level(idx, stim_q[f], o);
      end else begin
        exp_tx = 1'b1;
      end
      exp_done = (k > 1) && ((k - 1) % flen == 0) && ((k - 1) / flen <= n);
      exp_busy = (k >= 1) && (k <= n * flen);
      pushes   = (k + 1 < n) ? k + 1 : n;
      pops     = (k == 0) ? 0 : (((k - 1) / flen + 1 < n) ? (k - 1) / flen + 1 : n);
      exp_cnt  = 5'(pushes - pops);
      total++;
      if (tx_w[idx] !== exp_tx) $display("[TB] FAIL %s tx k=%0d got %b want %b", name, k, tx_w[idx], exp_tx);
      else passed++;
      total++;
      if (done_w[idx] !== exp_done) $display("[TB] FAIL %s tx_done k=%0d got %b want %b", name, k, done_w[idx], exp_done);
      else passed++;
      total++;
      if (busy_w[idx] !== exp_busy) $display("[TB] FAIL %s busy k=%0d got %b want %b", name, k, busy_w[idx], exp_busy);
      else passed++;
      total++;
      if (count_w[idx] !== exp_cnt) $display("[TB] FAIL %s fifo_count k=%0d got %0d want %0d", name, k, count_w[idx], exp_cnt);
      else passed++;
      total++;
      if (ready[idx] !== (exp_cnt != 5'd16)) $display("[TB] FAIL %s tx_ready k=%0d got %b want %b", name, k, ready[idx], exp_cnt != 5'd16);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_data = 8'h00;
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    #3 reset = 1'b0;
    #4;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_w[i] !== 1'b1) $display("[TB] FAIL reset tx inst=%0d got %b want 1", i, tx_w[i]); else passed++;
      total++;
      if (busy_w[i] !== 1'b0) $display("[TB] FAIL reset busy inst=%0d got %b want 0", i, busy_w[i]); else passed++;
      total++;
      if (done_w[i] !== 1'b0) $display("[TB] FAIL reset tx_done inst=%0d got %b want 0", i, done_w[i]); else passed++;
      total++;
      if (count_w[i] !== 5'd0) $display("[TB] FAIL reset fifo_count inst=%0d got %0d want 0", i, count_w[i]); else passed++;
      total++;
      if (ready[i] !== 1'b1) $display("[TB] FAIL reset tx_ready inst=%0d got %b want 1", i, ready[i]); else passed++;
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    stim_q = '{8'hA5};
    run_frames(0, "single_a5");
  endtask

  task automatic test_back_to_back();
    stim_q = '{8'h01, 8'h80, 8'hFF};
    run_frames(0, "back_to_back");
  endtask

  task automatic test_parity();
    stim_q = '{8'h07};
    run_frames(1, "parity_even");
    run_frames(2, "parity_odd");
  endtask

  task automatic test_two_stop();
    stim_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_frames(3, "two_stop");
  endtask

  task automatic test_random_frames();
    for (int idx = 0; idx < 4; idx++) begin
      stim_q.delete();
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) stim_q.push_back(8'($urandom));
      run_frames(idx, "random");
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    logic rdy, full_seen;
    int accepted, cyc;
    rx_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    d = 8'($urandom);
    accepted = 0;
    cyc = 0;
    full_seen = 1'b0;
    valid[0] = 1'b1;
    while (accepted < 40 && cyc < 6000) begin
      tx_data = d;
      rdy = ready[0];
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        exp_q.push_back(d);
        accepted++;
        d = d + 8'd1;
      end
      if (!full_seen && ready[0] === 1'b0) begin
        full_seen = 1'b1;
        total++;
        if (accepted != 17) $display("[TB] FAIL fifo_full accepted_before_full got %0d want 17", accepted); else passed++;
        total++;
        if (count_w[0] !== 5'd16) $display("[TB] FAIL fifo_full count_at_full got %0d want 16", count_w[0]); else passed++;
      end else if (full_seen && rdy) begin
        total++;
        if (ready[0] !== 1'b0) $display("[TB] FAIL fifo_full one_accept_per_frame got ready=%b want 0", ready[0]); else passed++;
      end
    end
    valid[0] = 1'b0;
    total++;
    if (accepted != 40) $display("[TB] FAIL fifo_full accept_timeout got %0d want 40", accepted); else passed++;
    cyc = 0;
    while (rx_q.size() < 40 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    total++;
    if (rx_q.size() != 40) $display("[TB] FAIL fifo_full rx_count got %0d want 40", rx_q.size()); else passed++;
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) $display("[TB] FAIL fifo_full order i=%0d got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
    end
    cyc = 0;
    while (busy_w[0] && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (busy_w[0] !== 1'b0) $display("[TB] FAIL fifo_full drain_idle got busy=%b want 0", busy_w[0]); else passed++;
    mon_en = 1'b0;
  endtask

  // Reset lands in data bit 3 of the first of four queued frames.
  task automatic test_reset_midframe();
    stim_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    for (int k = 0; k <= 46; k++) begin
      if (k < 4) begin
        tx_data = stim_q[k];
        valid[0] = 1'b1;
      end else begin
        valid[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    total++;
    if (tx_w[0] !== stim_q[0][3]) $display("[TB] FAIL reset_mid pre_bit3 got %b want %b", tx_w[0], stim_q[0][3]); else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (tx_w[0] !== 1'b1) $display("[TB] FAIL reset_mid tx got %b want 1", tx_w[0]); else passed++;
    total++;
    if (count_w[0] !== 5'd0) $display("[TB] FAIL reset_mid fifo_count got %0d want 0", count_w[0]); else passed++;
    total++;
    if (ready[0] !== 1'b1) $display("[TB] FAIL reset_mid tx_ready got %b want 1", ready[0]); else passed++;
    total++;
    if (busy_w[0] !== 1'b0) $display("[TB] FAIL reset_mid busy got %b want 0", busy_w[0]); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      total++;
      if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0 || busy_w[0] !== 1'b0)
        $display("[TB] FAIL reset_mid after_release k=%0d got tx=%b done=%b busy=%b want 1/0/0",
                 k, tx_w[0], done_w[0], busy_w[0]);
      else passed++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_random_frames();
    test_fifo_full();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Standalone buffered UART transmitter. It accepts bytes from on-chip logic over a valid/ready handshake into a circular FIFO, and serialises them LSB-first on a single tx line. The frame format is configurable: 8N1 by default, with optional parity and 2 stop bits. It is the transmit-side counterpart to the team's UART receive/echo logic, for blocks that originate serial traffic themselves.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, clock cycles per serial bit (>=2)
DATA_BIT, 8, data bits per frame (5..8)
FIFO_DEPTH, 16, FIFO entries (power of 2, >=2)
PARITY_EN, 0, 1 = append parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  DATA_BIT  byte to enqueue
tx_valid  input  1  tx_data is valid
tx_ready  output  1  FIFO can accept; transfer occurs on an edge where tx_valid && tx_ready
tx  output  1  serial line, idle high, registered
busy  output  1  FSM not in IDLE
tx_done  output  1  one-cycle pulse in the cycle after the last stop bit completes
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently in FIFO

Behaviour:
- Reset (reset=0, async): tx=1, busy=0, tx_done=0, fifo_count=0, tx_ready=1; FIFO pointers 0; FSM IDLE; bit/clock counters 0. Any in-flight frame is abandoned immediately with no partial stop bit. FIFO contents are discarded.
- FIFO: circular buffer with wrapping read and write pointers. tx_ready = (fifo_count != FIFO_DEPTH), combinational from the count register.
- Push and pop on the same edge: count unchanged, both pointers advance.
- When full, tx_ready=0 and tx_valid is ignored (no overflow, no write).
- Pop occurs only from IDLE, or at the end of the final stop bit, when fifo_count != 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count != 0: pop head into shift register, tx<=0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then drive bit 0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. After DATA_BIT bits, go to PARITY if PARITY_EN, else STOP with tx<=1.
  - PARITY: bit = XOR of data bits, inverted if PARITY_ODD. Lasts CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, pulse tx_done. If FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a byte accepted on edge E into an empty FIFO while IDLE gives tx falling after edge E+1. Total frame time = (1+DATA_BIT+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, exact with no jitter.
- Bit timing uses a clock counter that is reset at every bit boundary. Counter width is sufficient for STOP_BITS*CLKS_PER_BIT.
- The tx_data byte is captured at push. Later changes on tx_data have no effect on queued bytes.
- busy = 1 from the START edge until return to IDLE, including back-to-back frames.
- fifo_count reflects pushes and pops one edge after they occur.

Test Plan:
1. CLK_FREQ=1000, BAUD_RATE=100 (CLKS_PER_BIT=10), 8N1. Push 0xA5 once. Required: tx levels 0,1,0,1,0,0,1,0,1,1, each held exactly 10 cycles, starting 1 cycle after the accept edge. tx_done pulses once 100 cycles after tx falls. busy then 0.
2. Push 0x01, 0x80, 0xFF on consecutive edges. Required: three frames with no idle gap; tx falls at +1, +101 and +201 cycles; exactly 3 tx_done pulses; fifo_count goes 1,1,2 then decrements at each frame start.
3. Hold tx_valid=1 with incrementing data. Required: exactly 17 bytes accepted before tx_ready drops (the first is popped immediately), fifo_count=16. tx_ready re-asserts for one accept per frame end. Output byte order equals input order across pointer wrap.
4. PARITY_EN=1: push 0x07. PARITY_ODD=0 requires parity bit 1; PARITY_ODD=1 requires parity bit 0. Frame is 11 bits = 110 cycles.
5. STOP_BITS=2 with back-to-back bytes. Required: tx high exactly 20 cycles between the last data bit and the next start bit.
6. Queue 4 bytes, then assert reset low during data bit 3 of frame 1. Required: tx=1, fifo_count=0, tx_ready=1, busy=0 immediately (before the next edge). After release, tx stays 1 and no tx_done pulses.
